// File: rtl/pspin_her_gen.sv
// HER generator: interleaves NUM_MSGS messages round-robin into pspin's HER port,
// bounds in-flight packets with a credit counter and flags end-of-stream once all retire.
module pspin_her_gen #(
    parameter int          NUM_MSGS     = 4,
    parameter int          PKTS_PER_MSG = 8,
    parameter int          PKT_SIZE     = 512,
    parameter logic [31:0] BUF_BASE     = 32'h1C10_0000,
    parameter int          BUF_SLOTS    = 16,
    parameter int          MAX_INFLIGHT = 16,
    parameter int          ADDR_W       = 32,
    parameter int          SIZE_W       = 16,
    parameter int          MSGID_W      = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               her_valid_o,
    input  logic               her_ready_i,
    output logic [MSGID_W-1:0] her_msgid_o,
    output logic               her_eom_o,
    output logic [ADDR_W-1:0]  her_addr_o,
    output logic [SIZE_W-1:0]  her_size_o,
    input  logic               feedback_valid_i,
    output logic               feedback_ready_o,
    output logic               eos_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [31:0]        pkts_sent_o,
    output logic [31:0]        pkts_done_o
);
    localparam int PTR_W  = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam int SLOT_W = (BUF_SLOTS > 1) ? $clog2(BUF_SLOTS) : 1;
    localparam int CNT_W  = $clog2(PKTS_PER_MSG + 1);
    localparam int CRD_W  = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   rem_q [NUM_MSGS];
    logic [CNT_W-1:0]   rem_d [NUM_MSGS];
    logic [PTR_W-1:0]   rr_q, rr_d, cur_id, cand, sel_id;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CRD_W-1:0]   inflight_q, inflight_d;
    logic [31:0]        sent_q, done_q;
    logic               her_valid_q, her_eom_q, eos_q, err_q;
    logic [MSGID_W-1:0] her_msgid_q;
    logic [ADDR_W-1:0]  her_addr_q;
    logic [SIZE_W-1:0]  her_size_q;
    logic               her_hs, fb_hs, fb_ok, fb_err, sel_found, sel_eom, credit_ok;

    // Next-cycle view of counters, pointer and credits; the next descriptor is
    // selected from this view so back-to-back HERs need no bubble.
    always_comb begin
        her_hs     = her_valid_q & her_ready_i;
        fb_hs      = feedback_valid_i & (state_q != S_IDLE);
        fb_ok      = fb_hs & (inflight_q != '0);
        fb_err     = fb_hs & (inflight_q == '0);
        cur_id     = her_msgid_q[PTR_W-1:0];
        rem_d      = rem_q;
        rr_d       = rr_q;
        slot_d     = slot_q;
        inflight_d = inflight_q;
        if (her_hs) begin
            rem_d[cur_id] = rem_q[cur_id] - 1'b1;
            rr_d   = (cur_id == PTR_W'(NUM_MSGS - 1)) ? '0 : cur_id + 1'b1;
            slot_d = (slot_q == SLOT_W'(BUF_SLOTS - 1)) ? '0 : slot_q + 1'b1;
        end
        if (her_hs && !fb_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!her_hs && fb_ok) begin
            inflight_d = inflight_q - 1'b1;
        end
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MSGS; i++) begin
            cand = PTR_W'((int'(rr_d) + i) % NUM_MSGS);
            if (!sel_found && rem_d[cand] != '0) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
        sel_eom   = (rem_d[sel_id] == CNT_W'(1));
        credit_ok = (inflight_d < CRD_W'(MAX_INFLIGHT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            for (int m = 0; m < NUM_MSGS; m++) rem_q[m] <= '0;
            rr_q        <= '0;
            slot_q      <= '0;
            inflight_q  <= '0;
            sent_q      <= '0;
            done_q      <= '0;
            her_valid_q <= 1'b0;
            her_msgid_q <= '0;
            her_eom_q   <= 1'b0;
            her_addr_q  <= '0;
            her_size_q  <= '0;
            eos_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int m = 0; m < NUM_MSGS; m++) rem_q[m] <= rem_d[m];
            rr_q       <= rr_d;
            slot_q     <= slot_d;
            inflight_q <= inflight_d;
            if (her_hs) sent_q <= sent_q + 32'd1;
            if (fb_ok)  done_q <= done_q + 32'd1;
            if (fb_err) err_q  <= 1'b1;
            // A presented descriptor is only replaced after its handshake.
            if (state_q == S_ISSUE && (!her_valid_q || her_hs)) begin
                her_valid_q <= sel_found && credit_ok;
                her_msgid_q <= MSGID_W'(sel_id);
                her_eom_q   <= sel_eom;
                her_addr_q  <= ADDR_W'(BUF_BASE) + ADDR_W'(slot_d) * ADDR_W'(PKT_SIZE);
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q     <= S_ISSUE;
                        for (int m = 0; m < NUM_MSGS; m++) rem_q[m] <= CNT_W'(PKTS_PER_MSG);
                        rr_q        <= '0;
                        slot_q      <= '0;
                        inflight_q  <= '0;
                        sent_q      <= '0;
                        done_q      <= '0;
                        eos_q       <= 1'b0;
                        err_q       <= 1'b0;
                        her_valid_q <= 1'b1;
                        her_msgid_q <= '0;
                        her_eom_q   <= (PKTS_PER_MSG == 1);
                        her_addr_q  <= ADDR_W'(BUF_BASE);
                        her_size_q  <= SIZE_W'(PKT_SIZE);
                    end
                end
                S_ISSUE: if (her_hs && !sel_found) state_q <= S_DRAIN;
                S_DRAIN: begin
                    if (inflight_q == '0) begin
                        state_q <= S_DONE;
                        eos_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign her_valid_o      = her_valid_q;
    assign her_msgid_o      = her_msgid_q;
    assign her_eom_o        = her_eom_q;
    assign her_addr_o       = her_addr_q;
    assign her_size_o       = her_size_q;
    assign feedback_ready_o = (state_q != S_IDLE);
    assign eos_o            = eos_q;
    assign busy_o           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign err_o            = err_q;
    assign pkts_sent_o      = sent_q;
    assign pkts_done_o      = done_q;
endmodule

// File: tb/tb_pspin_her_gen.sv
// Bench for pspin_her_gen: default instance for streaming/credit/error scenarios,
// a 3-message single-packet instance for eom and mid-stream reset.
module tb_pspin_her_gen;
  localparam int          W    = 43;
  localparam logic [31:0] BASE = 32'h1C10_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        start_a = 0, ready_a = 0, fb_manual = 0, fb_auto = 0, fb_auto_v = 0;
  logic        fb_a;
  logic        valid_a, eom_a, fbr_a, eos_a, busy_a, err_a;
  logic [9:0]  msgid_a;
  logic [31:0] addr_a, sent_a, done_a;
  logic [15:0] size_a;
  assign fb_a = fb_manual | fb_auto_v;

  logic        start_b = 0, ready_b = 0, fb_b = 0;
  logic        valid_b, eom_b, fbr_b, eos_b, busy_b, err_b;
  logic [9:0]  msgid_b;
  logic [31:0] addr_b, sent_b, done_b;
  logic [15:0] size_b;

  pspin_her_gen dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .her_valid_o(valid_a), .her_ready_i(ready_a), .her_msgid_o(msgid_a),
    .her_eom_o(eom_a), .her_addr_o(addr_a), .her_size_o(size_a),
    .feedback_valid_i(fb_a), .feedback_ready_o(fbr_a),
    .eos_o(eos_a), .busy_o(busy_a), .err_o(err_a),
    .pkts_sent_o(sent_a), .pkts_done_o(done_a)
  );

  pspin_her_gen #(.NUM_MSGS(3), .PKTS_PER_MSG(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .her_valid_o(valid_b), .her_ready_i(ready_b), .her_msgid_o(msgid_b),
    .her_eom_o(eom_b), .her_addr_o(addr_b), .her_size_o(size_b),
    .feedback_valid_i(fb_b), .feedback_ready_o(fbr_b),
    .eos_o(eos_b), .busy_o(busy_b), .err_o(err_b),
    .pkts_sent_o(sent_b), .pkts_done_o(done_b)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int hs_a = 0, hs_b = 0, first_hs_a = 0, last_hs_a = 0, last_fb_a = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  int fb_due[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] desc(input int msgid, input logic eom, input logic [31:0] addr);
    return {10'(msgid), eom, addr};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Auto feedback: retire each HER three cycles after its handshake.
  always @(posedge clk) begin
    #1;
    fb_auto_v = 1'b0;
    if (fb_auto && fb_due.size() > 0 && fb_due[0] <= cyc) begin
      fb_auto_v = 1'b1;
      void'(fb_due.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      if (hs_a == 0) first_hs_a = cyc;
      last_hs_a = cyc;
      hs_a++;
      if (exp_q.size() == 0) check("a_unexpected_her", 64'd1, 64'd0);
      else check("a_desc", 64'({msgid_a, eom_a, addr_a}), 64'(exp_q.pop_front()));
      check("a_size", 64'(size_a), 64'd512);
      fb_due.push_back(cyc + 3);
    end
    if (fb_a && fbr_a) last_fb_a = cyc + 1;
    if (valid_b && ready_b) begin
      hs_b++;
      if (exp_b_q.size() == 0) check("b_unexpected_her", 64'd1, 64'd0);
      else check("b_desc", 64'({msgid_b, eom_b, addr_b}), 64'(exp_b_q.pop_front()));
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse(input bit sel_b);
    @(posedge clk);
    #1;
    if (sel_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_eos(input bit sel_b, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (sel_b ? eos_b : eos_a) begin
        at = cyc;
        break;
      end
    end
    check(sel_b ? "b_eos_timeout" : "a_eos_timeout", 64'(at >= 0), 64'd1);
  endtask

  task automatic wait_hs_b(input int n, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (hs_b >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_hs_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_flags", 64'({eos_a, busy_a, err_a, fbr_a}), 64'd0);
    check("rst_counts", {sent_a, done_a}, 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    rst = 1'b0;

    // Full stream: ready held high, feedback 3 cycles after each HER.
    for (int k = 0; k < 32; k++)
      exp_q.push_back(desc(k % 4, (k / 4) == 7, BASE + 32'((k % 16) * 512)));
    hs_a = 0;
    fb_due.delete();
    ready_a = 1'b1;
    fb_auto = 1'b1;
    pulse(1'b0);
    wait_eos(1'b0, 300, at);
    check("a_eos_latency", 64'(at), 64'(last_fb_a + 1));
    check("a_sent", 64'(sent_a), 64'd32);
    check("a_done", 64'(done_a), 64'd32);
    check("a_hs_cnt", 64'(hs_a), 64'd32);
    check("a_throughput", 64'(last_hs_a - first_hs_a), 64'd31);
    check("a_idle_outs", 64'({busy_a, valid_a}), 64'd0);
    check("a_sb_empty", 64'(exp_q.size()), 64'd0);

    // Feedback with nothing in flight while in DONE.
    fb_auto = 1'b0;
    ready_a = 1'b0;
    @(posedge clk);
    #1 fb_manual = 1'b1;
    @(posedge clk);
    #1 fb_manual = 1'b0;
    sample();
    check("a_err_set", 64'(err_a), 64'd1);
    check("a_err_done_cnt", 64'(done_a), 64'd32);
    check("a_err_eos_held", 64'(eos_a), 64'd1);
    pulse(1'b0);
    sample();
    check("a_start_clears", 64'({err_a, eos_a, busy_a}), 64'b001);
    check("a_start_counts", {sent_a, done_a}, 64'd0);

    // Feedback withheld: credits run out after MAX_INFLIGHT HERs.
    do_reset();
    for (int k = 0; k < 32; k++)
      exp_q.push_back(desc(k % 4, (k / 4) == 7, BASE + 32'((k % 16) * 512)));
    hs_a = 0;
    fb_due.delete();
    ready_a = 1'b1;
    pulse(1'b0);
    repeat (40) sample();
    check("a_credit_hs", 64'(hs_a), 64'd16);
    check("a_credit_valid", 64'(valid_a), 64'd0);
    check("a_credit_sent", 64'(sent_a), 64'd16);
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    fb_manual = 1'b1;
    @(posedge clk);
    #1 fb_manual = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("a_hold_valid", 64'(valid_a), 64'd1);
      check("a_hold_desc", 64'({msgid_a, eom_a, addr_a}), 64'(exp_q[0]));
    end
    @(posedge clk);
    #1;
    ready_a = 1'b1;
    fb_manual = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    fb_manual = 1'b0;
    sample();
    check("a_simul_hs", 64'(hs_a), 64'd17);
    check("a_simul_credit", 64'(valid_a), 64'd1);
    check("a_simul_cnt", {sent_a, done_a}, {32'd17, 32'd2});
    @(posedge clk);
    #1 ready_a = 1'b1;
    repeat (10) sample();
    check("a_refill_hs", 64'(hs_a), 64'd18);
    check("a_refill_valid", 64'(valid_b | valid_a), 64'd0);
    ready_a = 1'b0;
    exp_q.delete();

    // Three single-packet messages: every HER is an end-of-message.
    do_reset();
    for (int k = 0; k < 3; k++) exp_b_q.push_back(desc(k, 1'b1, BASE + 32'(k * 512)));
    hs_b = 0;
    ready_b = 1'b1;
    pulse(1'b1);
    wait_hs_b(3, 50);
    repeat (3) sample();
    check("b_drain", 64'({valid_b, busy_b, eos_b}), 64'b010);
    @(posedge clk);
    #1 fb_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 fb_b = 1'b0;
    wait_eos(1'b1, 20, at);
    check("b_counts", {sent_b, done_b}, {32'd3, 32'd3});
    check("b_err", 64'(err_b), 64'd0);
    check("b_sb_empty", 64'(exp_b_q.size()), 64'd0);

    // Reset right after the second HER drops the pending third one.
    do_reset();
    for (int k = 0; k < 3; k++) exp_b_q.push_back(desc(k, 1'b1, BASE + 32'(k * 512)));
    hs_b = 0;
    pulse(1'b1);
    wait_hs_b(2, 50);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("b_rst_valid", 64'(valid_b), 64'd0);
    check("b_rst_desc", 64'({msgid_b, eom_b, addr_b, size_b}), 64'd0);
    check("b_rst_flags", 64'({eos_b, busy_b, err_b, fbr_b}), 64'd0);
    check("b_rst_counts", {sent_b, done_b}, 64'd0);
    check("b_rst_dropped", 64'(exp_b_q.size()), 64'd1);
    exp_b_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) sample();
    check("b_idle_after", 64'({valid_b, busy_b, fbr_b, hs_b == 2}), 64'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
